// File: rtl/cmos_dvp_tx.sv
// DVP camera-port transmitter: turns a 16-bit RGB565 pixel stream into sensor-style
// vsync/href/byte output, high byte first, with the byte clock equal to clk.
module cmos_dvp_tx #(
   parameter int unsigned H_ACTIVE  = 1024,
   parameter int unsigned V_ACTIVE  = 768,
   parameter int unsigned H_BLANK   = 256,
   parameter int unsigned VSYNC_LEN = 1000,
   parameter int unsigned V_BACK    = 1000,
   parameter int unsigned V_FRONT   = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [15:0] pix_data,
   input  logic        pix_valid,
   output logic        pix_ready,
   output logic        cmos_vsync,
   output logic        cmos_href,
   output logic [7:0]  cmos_db,
   output logic        frame_start,
   output logic        frame_done,
   output logic        underrun
);

   localparam logic [15:0] HLast  = 16'(H_ACTIVE - 1);
   localparam logic [15:0] VLast  = 16'(V_ACTIVE - 1);
   localparam logic [15:0] HbLast = 16'(H_BLANK - 1);
   localparam logic [15:0] VsLast = 16'(VSYNC_LEN - 1);
   localparam logic [15:0] VbLast = 16'(V_BACK - 1);
   localparam logic [15:0] VfLast = 16'(V_FRONT - 1);

   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StVsync  = 3'd1;
   localparam logic [2:0] StVback  = 3'd2;
   localparam logic [2:0] StActive = 3'd3;
   localparam logic [2:0] StHblank = 3'd4;
   localparam logic [2:0] StVfront = 3'd5;

   logic [2:0]  state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] line_q, line_d;
   logic        phase_q, phase_d;
   logic [7:0]  lo_q, lo_d;
   logic        pix_ready_q, pix_ready_d;
   logic        vsync_q, vsync_d;
   logic        href_q, href_d;
   logic [7:0]  db_q, db_d;
   logic        frame_start_q, frame_start_d;
   logic        frame_done_q, frame_done_d;
   logic        underrun_q, underrun_d;
   logic        accept;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      line_d  = line_q;
      phase_d = phase_q;
      case (state_q)
         StIdle: begin
            if (enable) begin
               state_d = StVsync;
               cnt_d   = '0;
            end
         end
         StVsync: begin
            if (cnt_q == VsLast) begin
               state_d = StVback;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StVback: begin
            if (cnt_q == VbLast) begin
               state_d = StActive;
               cnt_d   = '0;
               line_d  = '0;
               phase_d = 1'b0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StActive: begin
            // cnt counts pixels; phase selects the byte within the pixel
            phase_d = ~phase_q;
            if (phase_q) begin
               if (cnt_q == HLast) begin
                  cnt_d   = '0;
                  state_d = (line_q == VLast) ? StVfront : StHblank;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
         end
         StHblank: begin
            if (cnt_q == HbLast) begin
               state_d = StActive;
               cnt_d   = '0;
               phase_d = 1'b0;
               line_d  = line_q + 16'd1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StVfront: begin
            if (cnt_q == VfLast) begin
               state_d = enable ? StVsync : StIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so they line up with state_q once registered.
   always_comb begin
      accept        = pix_valid & pix_ready_q;
      vsync_d       = (state_d == StVsync);
      href_d        = (state_d == StActive);
      frame_start_d = (state_d == StVsync) && (cnt_d == 16'd0);
      frame_done_d  = (state_d == StVfront) && (cnt_d == VfLast);
      pix_ready_d   = ((state_d == StVback) && (cnt_d == VbLast)) ||
                      ((state_d == StHblank) && (cnt_d == HbLast)) ||
                      ((state_d == StActive) && phase_d && (cnt_d != HLast));
      underrun_d    = underrun_q | (pix_ready_q & ~pix_valid);
      lo_d          = lo_q;
      db_d          = 8'h00;
      if (state_d == StActive) begin
         if (!phase_d) begin
            db_d = accept ? pix_data[15:8] : 8'h00;
            lo_d = accept ? pix_data[7:0] : 8'h00;
         end else begin
            db_d = lo_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         line_q        <= '0;
         phase_q       <= 1'b0;
         lo_q          <= '0;
         pix_ready_q   <= 1'b0;
         vsync_q       <= 1'b0;
         href_q        <= 1'b0;
         db_q          <= '0;
         frame_start_q <= 1'b0;
         frame_done_q  <= 1'b0;
         underrun_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         line_q        <= line_d;
         phase_q       <= phase_d;
         lo_q          <= lo_d;
         pix_ready_q   <= pix_ready_d;
         vsync_q       <= vsync_d;
         href_q        <= href_d;
         db_q          <= db_d;
         frame_start_q <= frame_start_d;
         frame_done_q  <= frame_done_d;
         underrun_q    <= underrun_d;
      end
   end

   assign pix_ready   = pix_ready_q;
   assign cmos_vsync  = vsync_q;
   assign cmos_href   = href_q;
   assign cmos_db     = db_q;
   assign frame_start = frame_start_q;
   assign frame_done  = frame_done_q;
   assign underrun    = underrun_q;

endmodule

// File: tb/tb_cmos_dvp_tx.sv
// Bench for cmos_dvp_tx: frame-offset reference model plus a word scoreboard that
// rebuilds 16-bit pixels from the DVP bytes and compares them to what was sent.
module tb_cmos_dvp_tx;

   localparam int VS    = 3;
   localparam int VB    = 2;
   localparam int HA    = 4;
   localparam int VA    = 3;
   localparam int HB    = 2;
   localparam int VF    = 2;
   localparam int LINE  = 2 * HA + HB;
   localparam int ACT   = VA * 2 * HA + (VA - 1) * HB;
   localparam int FRAME = VS + VB + ACT + VF;

   logic        clk;
   logic        rst;
   logic        enable;
   logic [15:0] pix_data;
   logic        pix_valid;
   logic        pix_ready;
   logic        cmos_vsync;
   logic        cmos_href;
   logic [7:0]  cmos_db;
   logic        frame_start;
   logic        frame_done;
   logic        underrun;

   cmos_dvp_tx #(
      .H_ACTIVE  (HA),
      .V_ACTIVE  (VA),
      .H_BLANK   (HB),
      .VSYNC_LEN (VS),
      .V_BACK    (VB),
      .V_FRONT   (VF)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .pix_data    (pix_data),
      .pix_valid   (pix_valid),
      .pix_ready   (pix_ready),
      .cmos_vsync  (cmos_vsync),
      .cmos_href   (cmos_href),
      .cmos_db     (cmos_db),
      .frame_start (frame_start),
      .frame_done  (frame_done),
      .underrun    (underrun)
   );

   int          errors = 0;
   int          checks = 0;
   int          off = -1;
   bit          und_m = 1'b0;
   bit          mon_en = 1'b0;
   int          valid_pct = 100;
   logic [15:0] next_pix = 16'h1234;
   logic [15:0] exp_q[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic bit in_href(int k);
      int a;
      a = k - VS - VB;
      return (a >= 0) && (a < ACT) && ((a % LINE) < 2 * HA);
   endfunction

   function automatic bit phase0(int k);
      int a;
      a = k - VS - VB;
      return in_href(k) && (((a % LINE) % 2) == 0);
   endfunction

   function automatic bit exp_ready(int k);
      return (k >= 0) && phase0(k + 1);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: frame offset advances one per cycle; the source's choices feed the scoreboard.
   initial begin
      forever begin
         @(posedge clk);
         if (rst) begin
            off   = -1;
            und_m = 1'b0;
            exp_q.delete();
         end else begin
            if (exp_ready(off)) begin
               if (pix_valid) begin
                  exp_q.push_back(next_pix);
                  next_pix = next_pix + 16'd1;
               end else begin
                  exp_q.push_back(16'h0000);
                  und_m = 1'b1;
               end
            end
            if (off < 0 || off == FRAME - 1) off = enable ? 0 : -1;
            else off = off + 1;
         end
      end
   end

   // Monitor: timing against the model, bytes paired into words against the scoreboard.
   initial begin
      bit         mph;
      logic [7:0] hi;
      mph = 1'b0;
      hi  = 8'h00;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            chk("vsync", 32'(cmos_vsync), 32'(off >= 0 && off < VS));
            chk("href", 32'(cmos_href), 32'(in_href(off)));
            chk("pix_ready", 32'(pix_ready), 32'(exp_ready(off)));
            chk("frame_start", 32'(frame_start), 32'(off == 0));
            chk("frame_done", 32'(frame_done), 32'(off == FRAME - 1));
            chk("underrun", 32'(underrun), 32'(und_m));
            if (!cmos_href) begin
               chk("db_idle", 32'(cmos_db), 32'h0);
               mph = 1'b0;
            end else if (!mph) begin
               hi  = cmos_db;
               mph = 1'b1;
            end else begin
               mph = 1'b0;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL word: got %0h expected none (queue empty) at %0t",
                           {hi, cmos_db}, $time);
               end else begin
                  chk("word", 32'({hi, cmos_db}), 32'(exp_q.pop_front()));
               end
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         pix_valid = ($urandom_range(0, 99) < valid_pct);
         pix_data  = pix_valid ? next_pix : 16'($urandom);
      end
   endtask

   initial begin
      rst       = 1'b1;
      enable    = 1'b0;
      pix_valid = 1'b0;
      pix_data  = 16'h0000;
      @(posedge clk);
      #1;
      mon_en = 1'b1;
      step(2);
      rst    = 1'b0;
      enable = 1'b1;
      step(3 * FRAME + 5);
      valid_pct = 60;
      step(2 * FRAME);
      enable = 1'b0;
      step(2 * FRAME);
      valid_pct = 100;
      enable    = 1'b1;
      step(VS + VB + 6);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      step(FRAME + 5);
      enable = 1'b0;
      step(2 * FRAME);
      chk("queue_empty", 32'(exp_q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
